// File: rtl/writeback_stage.sv
// Writeback stage: commits ALU results directly and formats data-memory load returns.
// Define WB_FORWARD_EN to add combinational fwd_* outputs that mirror the register-file write port.
module writeback_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_alu_result,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_dst,
  input  logic        in_reg_write,
  input  logic        in_mem_to_reg,
  input  logic [1:0]  in_ld_size,
  input  logic        in_ld_signed,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [31:0] wr_data,
  output logic [4:0]  wr_reg,
  output logic        reg_write,
`ifdef WB_FORWARD_EN
  output logic        fwd_valid,
  output logic [4:0]  fwd_reg,
  output logic [31:0] fwd_data,
`endif
  output logic [31:0] retire_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_COMMIT   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_load_done;
  logic [4:0]  w_in_dest;

  logic [4:0]  r_dest;
  logic        r_reg_write;
  logic [1:0]  r_ld_size;
  logic        r_ld_signed;
  logic [1:0]  r_lane;

  logic [31:0] r_wr_data;
  logic [4:0]  r_wr_reg;
  logic        r_reg_write_out;
  logic [31:0] r_retire_count;

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = in_mem_to_reg ? S_WAIT_MEM : S_COMMIT;
      end
      S_WAIT_MEM: begin
        if (mem_rvalid) w_next = S_COMMIT;
      end
      S_COMMIT: begin
        in_ready = 1'b1;
        if (in_valid) w_next = in_mem_to_reg ? S_WAIT_MEM : S_COMMIT;
        else          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept    = in_valid & in_ready;
  assign w_load_done = (r_state == S_WAIT_MEM) & mem_rvalid;
  assign w_in_dest   = in_reg_dst ? in_rd : in_rt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dest      <= 5'd0;
      r_reg_write <= 1'b0;
      r_ld_size   <= 2'd0;
      r_ld_signed <= 1'b0;
      r_lane      <= 2'd0;
    end else if (w_accept) begin
      r_dest      <= w_in_dest;
      r_reg_write <= in_reg_write;
      r_ld_size   <= in_ld_size;
      r_ld_signed <= in_ld_signed;
      r_lane      <= in_alu_result[1:0];
    end
  end

  // Little-endian lane pick; halfwords use only the upper address bit
  always_comb begin
    w_byte      = 8'd0;
    w_half      = 16'd0;
    w_load_data = mem_rdata;
    case (r_lane)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_ld_size)
      2'b00:   w_load_data = {{24{r_ld_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{16{r_ld_signed & w_half[15]}}, w_half};
      default: w_load_data = mem_rdata;
    endcase
  end

  // Commit outputs are loaded on the edge that enters COMMIT, so they are valid during COMMIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_data       <= 32'd0;
      r_wr_reg        <= 5'd0;
      r_reg_write_out <= 1'b0;
      r_retire_count  <= 32'd0;
    end else begin
      r_reg_write_out <= 1'b0;
      if (w_accept && !in_mem_to_reg) begin
        r_wr_data       <= in_alu_result;
        r_wr_reg        <= w_in_dest;
        r_reg_write_out <= in_reg_write & (w_in_dest != 5'd0);
        r_retire_count  <= r_retire_count + 32'd1;
      end else if (w_load_done) begin
        r_wr_data       <= w_load_data;
        r_wr_reg        <= r_dest;
        r_reg_write_out <= r_reg_write & (r_dest != 5'd0);
        r_retire_count  <= r_retire_count + 32'd1;
      end
    end
  end

  assign wr_data      = r_wr_data;
  assign wr_reg       = r_wr_reg;
  assign reg_write    = r_reg_write_out;
  assign retire_count = r_retire_count;

`ifdef WB_FORWARD_EN
  assign fwd_valid = r_reg_write_out;
  assign fwd_reg   = r_wr_reg;
  assign fwd_data  = r_wr_data;
`endif

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1: upstream MEM stage presents an instruction.
REQ-004 SHALL have port in_ready, output, 1: stage accepts the instruction this cycle.
REQ-005 SHALL have port in_alu_result, input, 32: ALU result or load address.
REQ-006 SHALL have ports in_rt and in_rd, input, 5 each: instruction[20:16] and instruction[15:11].
REQ-007 SHALL have ports in_reg_dst, in_reg_write and in_mem_to_reg, input, 1 each: RegDst, RegWrite and MemtoReg controls.
REQ-008 SHALL have port in_ld_size, input, 2: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 SHALL have port in_ld_signed, input, 1: sign-extend sub-word loads.
REQ-010 SHALL have ports mem_rdata, input, 32, and mem_rvalid, input, 1: data-memory read return.
REQ-011 SHALL have ports wr_data, output, 32; wr_reg, output, 5; and reg_write, output, 1: register-file write port.
REQ-012 SHALL have port retire_count, output, 32: number of instructions committed.
REQ-013 SHALL have ports fwd_valid, output, 1; fwd_reg, output, 5; and fwd_data, output, 32, present only under WB_FORWARD_EN.

Function
REQ-014 SHALL implement three states: IDLE, WAIT_MEM and COMMIT.
REQ-015 SHALL drive in_ready=1 in IDLE and COMMIT, and in_ready=0 in WAIT_MEM.
REQ-016 SHALL accept an instruction on in_valid&in_ready and latch all in_* fields.
REQ-017 SHALL set destination to in_rd when in_reg_dst=1, else in_rt.
REQ-018 SHALL, on accept with in_mem_to_reg=0, go to COMMIT next cycle with data = in_alu_result; this is 1-cycle latency.
REQ-019 SHALL, on accept with in_mem_to_reg=1, go to WAIT_MEM; on mem_rvalid it SHALL latch the formatted load data and go to COMMIT.
REQ-020 SHALL select the load byte/half lane by alu_result[1:0] (half uses bit 1), little-endian, then zero- or sign-extend per in_ld_signed.
REQ-021 SHALL, in COMMIT, drive wr_reg/wr_data for exactly one cycle and reg_write = latched RegWrite AND (dest != 0).
REQ-022 SHALL suppress writes to register 0 while still counting the instruction retired.
REQ-023 SHALL increment retire_count by 1 per COMMIT cycle, wrapping 0xFFFFFFFF to 0.
REQ-024 SHALL, in COMMIT with in_valid=1, accept back-to-back (next state COMMIT or WAIT_MEM); otherwise it SHALL return to IDLE.
REQ-025 SHALL ignore mem_rvalid outside WAIT_MEM.
REQ-026 SHALL hold reg_write=0 in IDLE and WAIT_MEM; wr_reg/wr_data SHALL hold their last values.

Reset
REQ-027 SHALL, on rst, force IDLE and clear reg_write, wr_reg, wr_data, retire_count and the latched fields to 0.
REQ-028 SHALL, on rst asserted during WAIT_MEM or COMMIT, abandon the instruction: no write and no count.
REQ-029 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-030 SHALL compile forwarding outputs only when WB_FORWARD_EN is defined.
REQ-031 SHALL, with WB_FORWARD_EN defined, drive fwd_valid=reg_write, fwd_reg=wr_reg and fwd_data=wr_data combinationally.
REQ-032 SHALL, in WAIT_MEM with WB_FORWARD_EN defined, hold fwd_valid=0 (load-use stall is owned upstream).
REQ-033 SHALL, without WB_FORWARD_EN, omit the fwd_* ports entirely with no other behavioural change.

Verification
REQ-034 SHALL test an ALU op: accept in_alu_result=0x0000_1234, rd=5, reg_dst=1, reg_write=1 -> next cycle reg_write=1, wr_reg=5, wr_data=0x1234, retire_count=1.
REQ-035 SHALL test a signed byte load: alu_result[1:0]=2, mem_rdata=0x0080_0000 after 3 wait cycles -> in_ready=0 while waiting, then wr_data=0xFFFF_FF80 the cycle after mem_rvalid.
REQ-036 SHALL test a write to $0: rt=0, reg_dst=0, reg_write=1 -> reg_write stays 0 and retire_count increments.
REQ-037 SHALL test back-to-back: 4 ALU ops on consecutive cycles -> 4 consecutive reg_write pulses and retire_count=4.
REQ-038 SHALL test rst asserted in WAIT_MEM, then mem_rvalid -> no write, retire_count=0, state IDLE.
REQ-039 SHALL test retire_count preloaded near wrap at 0xFFFFFFFF plus one commit -> retire_count=0.
